btn_event: RTL and testbench



---
 rtl/btn_pkg.sv | 18 +
 rtl/edge_det.sv | 25 ++
 rtl/btn_event.sv | 139 +++++++++++++
 tb/tb_btn_event.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/btn_pkg.sv
// Shared types for the button event block: FSM state encoding and a counter-width helper.
package btn_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESSED = 2'd1,
    LONG    = 2'd2
  } btn_state_e;

  // Bits needed to hold any value in 0..max_val (at least one bit).
  function automatic int unsigned cnt_w(input int unsigned max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

  localparam int unsigned LONG_MS_DEF = 1000;
  localparam int unsigned HOLD_W_DEF  = cnt_w(LONG_MS_DEF);

endpackage

// File: rtl/edge_det.sv
// Registered level with combinational rise/fall strobes against that level.
// Reusable for any debounced input vector.
module edge_det #(
  parameter int unsigned W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] lvl_o,
  output logic [W-1:0] rise_o,
  output logic [W-1:0] fall_o
);

  logic [W-1:0] lvl_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lvl_q <= '0;
    else        lvl_q <= d_i;
  end

  assign lvl_o  = lvl_q;
  assign rise_o = d_i & ~lvl_q;
  assign fall_o = ~d_i & lvl_q;

endmodule

// File: rtl/btn_event.sv
// Debounced button level -> press/release/click/long/repeat pulses and a wrapping press count.
// Auto-repeat is built only when BTN_EVENT_REPEAT_EN is defined; otherwise evt_repeat is tied low.
module btn_event
  import btn_pkg::*;
#(
  parameter int unsigned LONG_MS   = 1000,
  parameter int unsigned REPEAT_MS = 200,
  parameter int unsigned CNT_W     = 8
) (
  input  logic             clk_1ms,
  input  logic             rst_n,
  input  logic             pb_level,
  output logic             evt_press,
  output logic             evt_release,
  output logic             evt_click,
  output logic             evt_long,
  output logic             evt_repeat,
  output logic             held,
  output logic [CNT_W-1:0] press_cnt
);

  localparam int unsigned     HOLD_W    = cnt_w(LONG_MS);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_MS - 1);
  localparam logic [HOLD_W-1:0] HOLD_SAT  = HOLD_W'(LONG_MS);

  logic rise, fall;

  edge_det #(.W(1)) u_edge (
    .clk    (clk_1ms),
    .rst_n  (rst_n),
    .d_i    (pb_level),
    .lvl_o  (held),
    .rise_o (rise),
    .fall_o (fall)
  );

  btn_state_e        state_q, state_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              press_q, press_d;
  logic              rel_q, rel_d;
  logic              click_q, click_d;
  logic              long_q, long_d;

  always_ff @(posedge clk_1ms or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      hold_q  <= '0;
      cnt_q   <= '0;
      press_q <= 1'b0;
      rel_q   <= 1'b0;
      click_q <= 1'b0;
      long_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      cnt_q   <= cnt_d;
      press_q <= press_d;
      rel_q   <= rel_d;
      click_q <= click_d;
      long_q  <= long_d;
    end
  end

  // Release is checked before the threshold, so a release on the threshold edge wins.
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    cnt_d   = cnt_q;
    press_d = 1'b0;
    rel_d   = 1'b0;
    click_d = 1'b0;
    long_d  = 1'b0;
    if (rise) begin
      press_d = 1'b1;
      cnt_d   = cnt_q + CNT_W'(1);
      hold_d  = '0;
      state_d = PRESSED;
    end else if (fall) begin
      rel_d   = 1'b1;
      click_d = (state_q == PRESSED);
      hold_d  = '0;
      state_d = IDLE;
    end else if (pb_level && state_q == PRESSED) begin
      if (hold_q == HOLD_LAST) begin
        hold_d  = HOLD_SAT;
        long_d  = 1'b1;
        state_d = LONG;
      end else begin
        hold_d  = hold_q + HOLD_W'(1);
      end
    end
  end

  assign evt_press   = press_q;
  assign evt_release = rel_q;
  assign evt_click   = click_q;
  assign evt_long    = long_q;
  assign press_cnt   = cnt_q;

`ifdef BTN_EVENT_REPEAT_EN
  localparam int unsigned      REP_W    = cnt_w(REPEAT_MS);
  localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_MS - 1);

  logic [REP_W-1:0] rep_q, rep_d;
  logic             rep_evt_q, rep_evt_d;

  always_ff @(posedge clk_1ms or negedge rst_n) begin
    if (!rst_n) begin
      rep_q     <= '0;
      rep_evt_q <= 1'b0;
    end else begin
      rep_q     <= rep_d;
      rep_evt_q <= rep_evt_d;
    end
  end

  // rep_q counts held edges since evt_long; it sits at 0 outside LONG.
  always_comb begin
    rep_d     = rep_q;
    rep_evt_d = 1'b0;
    if (fall || state_q != LONG) begin
      rep_d = '0;
    end else if (pb_level) begin
      if (rep_q == REP_LAST) begin
        rep_d     = '0;
        rep_evt_d = 1'b1;
      end else begin
        rep_d = rep_q + REP_W'(1);
      end
    end
  end

  assign evt_repeat = rep_evt_q;
`else
  assign evt_repeat = 1'b0;
`endif

endmodule

// File: tb/tb_btn_event.sv
// Randomized + directed bench for btn_event with an event-level reference model and scoreboard.
module tb_btn_event;

  localparam int LONG = 10;
  localparam int REP  = 4;
  localparam int CW   = 8;
`ifdef BTN_EVENT_REPEAT_EN
  localparam bit REP_EN = 1'b1;
`else
  localparam bit REP_EN = 1'b0;
`endif

  logic          clk_1ms = 1'b0;
  logic          rst_n   = 1'b0;
  logic          pb_level = 1'b0;
  logic          evt_press, evt_release, evt_click, evt_long, evt_repeat, held;
  logic [CW-1:0] press_cnt;

  btn_event #(.LONG_MS(LONG), .REPEAT_MS(REP), .CNT_W(CW)) dut (
    .clk_1ms     (clk_1ms),
    .rst_n       (rst_n),
    .pb_level    (pb_level),
    .evt_press   (evt_press),
    .evt_release (evt_release),
    .evt_click   (evt_click),
    .evt_long    (evt_long),
    .evt_repeat  (evt_repeat),
    .held        (held),
    .press_cnt   (press_cnt)
  );

  always #5 clk_1ms = ~clk_1ms;

  // ev bits: {press, release, click, long, repeat}
  typedef struct {
    int unsigned   stamp;
    logic [4:0]    ev;
    logic [CW-1:0] cnt;
  } exp_t;

  exp_t          q[$];
  int            checks = 0;
  int            failures = 0;
  int unsigned   ecnt = 0;
  int            press_seen = 0;
  bit            m_prev = 1'b0;
  int            m_run = 0;
  logic [CW-1:0] m_cnt = '0;

  always @(posedge clk_1ms) ecnt <= ecnt + 1;

  // Model: m_run = edges held since the press edge; events derived arithmetically.
  task automatic model_step(input bit v);
    logic [4:0] ev;
    ev = '0;
    if (v && !m_prev) begin
      ev[4] = 1'b1;
      m_cnt = m_cnt + 1'b1;
      m_run = 0;
    end else if (v && m_prev) begin
      m_run++;
      if (m_run == LONG) ev[1] = 1'b1;
      else if (REP_EN && m_run > LONG && ((m_run - LONG) % REP) == 0) ev[0] = 1'b1;
    end else if (!v && m_prev) begin
      ev[3] = 1'b1;
      if (m_run < LONG) ev[2] = 1'b1;
    end
    m_prev = v;
    if (ev != '0) q.push_back('{ecnt + 1, ev, m_cnt});
  endtask

  task automatic drive(input bit v);
    @(posedge clk_1ms); #2;
    pb_level = v;
    model_step(v);
  endtask

  task automatic do_reset();
    @(posedge clk_1ms); #2;
    rst_n = 1'b0;
    q.delete();
    m_prev = 1'b0; m_run = 0; m_cnt = '0;
    #1;
    checks++;
    if ({evt_press, evt_release, evt_click, evt_long, evt_repeat, held} !== 6'b0 || press_cnt !== '0) begin
      failures++;
      $display("FAIL reset_state evt=%b held=%b cnt=%0d expected all 0",
               {evt_press, evt_release, evt_click, evt_long, evt_repeat}, held, press_cnt);
    end
    repeat (2) @(posedge clk_1ms);
    #2;
    rst_n = 1'b1;
    model_step(pb_level);
  endtask

  always @(negedge clk_1ms) begin
    logic [4:0] dev;
    exp_t       e;
    if (rst_n) begin
      dev = {evt_press, evt_release, evt_click, evt_long, evt_repeat};
      while (q.size() > 0 && q[0].stamp < ecnt) begin
        e = q.pop_front();
        checks++; failures++;
        $display("FAIL missed_evt edge=%0d got=none expected=%b", e.stamp, e.ev);
      end
      if (q.size() > 0 && q[0].stamp == ecnt) begin
        e = q.pop_front();
        checks++;
        if (dev !== e.ev || press_cnt !== e.cnt) begin
          failures++;
          $display("FAIL evt edge=%0d got ev=%b cnt=%0d expected ev=%b cnt=%0d",
                   ecnt, dev, press_cnt, e.ev, e.cnt);
        end
      end else if (dev != '0) begin
        checks++; failures++;
        $display("FAIL unexpected_evt edge=%0d got=%b expected=00000", ecnt, dev);
      end
      if (evt_press) press_seen++;
      checks++;
      if ((evt_long && evt_repeat) || (evt_press && evt_release)) begin
        failures++;
        $display("FAIL exclusive edge=%0d got ev=%b", ecnt, dev);
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL timeout edge=%0d", ecnt);
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

  initial begin
    int p0;
    do_reset();

    // 256 short presses wrap the counter back to 0
    p0 = press_seen;
    for (int i = 0; i < 256; i++) begin
      drive(1'b1);
      drive(1'b0);
    end
    drive(1'b0);
    drive(1'b0);
    checks++;
    if (press_cnt !== CW'(0)) begin
      failures++;
      $display("FAIL wrap_cnt got=%0d expected=0", press_cnt);
    end
    checks++;
    if (press_seen - p0 != 256) begin
      failures++;
      $display("FAIL wrap_presses got=%0d expected=256", press_seen - p0);
    end

    // short press, long hold, release exactly on the threshold edge
    repeat (5)  drive(1'b1);
    repeat (3)  drive(1'b0);
    repeat (20) drive(1'b1);
    repeat (3)  drive(1'b0);
    repeat (10) drive(1'b1);
    repeat (3)  drive(1'b0);

    // reset mid-hold, then a fresh press right after reset release
    repeat (6) drive(1'b1);
    do_reset();
    repeat (3) drive(1'b1);
    repeat (2) drive(1'b0);

    for (int i = 0; i < 40; i++) begin
      int hi, lo;
      hi = $urandom_range(1, 26);
      lo = $urandom_range(1, 4);
      repeat (hi) drive(1'b1);
      repeat (lo) drive(1'b0);
    end

    repeat (3) drive(1'b0);
    @(negedge clk_1ms); #1;
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain pending=%0d expected=0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
